// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : shared UART constants (data width, parity encoding, entry width)
// Revision : 1.0
// ============================================================================
package uart_pkg;

   localparam int UART_DATA_BITS  = 8;
   localparam int UART_ENTRY_BITS = UART_DATA_BITS + 1;

   localparam logic [1:0] PARITY_NONE = 2'd0;
   localparam logic [1:0] PARITY_ODD  = 2'd1;
   localparam logic [1:0] PARITY_EVEN = 2'd2;

endpackage
`default_nettype wire

// File: rtl/uart_fifo_ram.sv
`default_nettype none
// ============================================================================
// uart_fifo_ram : simple dual-port storage, one write port, registered read
// Revision : 1.0
// ============================================================================
module uart_fifo_ram
   import uart_pkg::*;
#(
   parameter int WIDTH      = UART_ENTRY_BITS,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [WIDTH-1:0]      rd_data
);

   logic [WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];

   // Array is deliberately unreset so it can map onto plain RAM
   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_mem[wr_addr] <= wr_data;
      end
   end

   // A same-address write and read returns the old contents
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data <= '0;
      end else if (rd_en) begin
         rd_data <= r_mem[rd_addr];
      end
   end

endmodule
`default_nettype wire

// File: rtl/uart_rx_buffer.sv
`default_nettype none
// ============================================================================
// uart_rx_buffer : receive byte FIFO with error flag, occupancy and overrun
// Revision : 1.0
// ============================================================================
module uart_rx_buffer
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = UART_DATA_BITS,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 wr_valid,
   input  logic [DATA_BITS-1:0] wr_data,
   input  logic                 wr_err,
   input  logic                 rd_en,
   output logic [DATA_BITS-1:0] rd_data,
   output logic                 rd_err,
   output logic                 rd_valid,
   output logic                 empty,
   output logic                 full,
   output logic [ADDR_WIDTH:0]  count,
   output logic                 overrun,
   input  logic                 clr_overrun
);

   localparam int                ENTRY_W = DATA_BITS + 1;
   localparam logic [ADDR_WIDTH:0] c_DEPTH = (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;

   logic [ADDR_WIDTH-1:0] r_wr_ptr;
   logic [ADDR_WIDTH-1:0] r_rd_ptr;
   logic [ENTRY_W-1:0]    w_rd_entry;
   logic                  w_wr_acc;
   logic                  w_rd_acc;
   logic                  w_drop;
   logic [ADDR_WIDTH:0]   w_count_nxt;

   // A full FIFO still takes a write when the same cycle frees a slot
   assign w_rd_acc = rd_en && !empty;
   assign w_wr_acc = wr_valid && (!full || rd_en);
   assign w_drop   = wr_valid && full && !rd_en;

   always_comb begin
      w_count_nxt = count;
      case ({w_wr_acc, w_rd_acc})
         2'b10:   w_count_nxt = count + 1'b1;
         2'b01:   w_count_nxt = count - 1'b1;
         default: w_count_nxt = count;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         count    <= '0;
         empty    <= 1'b1;
         full     <= 1'b0;
         overrun  <= 1'b0;
         rd_valid <= 1'b0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_rd_acc) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         count    <= w_count_nxt;
         empty    <= (w_count_nxt == '0);
         full     <= (w_count_nxt == c_DEPTH);
         rd_valid <= w_rd_acc;
         if (w_drop) begin
            overrun <= 1'b1;
         end else if (clr_overrun) begin
            overrun <= 1'b0;
         end
      end
   end

   uart_fifo_ram #(
      .WIDTH      (ENTRY_W),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (w_wr_acc),
      .wr_addr (r_wr_ptr),
      .wr_data ({wr_err, wr_data}),
      .rd_en   (w_rd_acc),
      .rd_addr (r_rd_ptr),
      .rd_data (w_rd_entry)
   );

   assign rd_data = w_rd_entry[DATA_BITS-1:0];
   assign rd_err  = w_rd_entry[DATA_BITS];

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_buffer.sv
`default_nettype none
// ============================================================================
// tb_uart_rx_buffer : scoreboard bench for uart_rx_buffer
// Revision : 1.0
// ============================================================================
module tb_uart_rx_buffer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       wr_valid = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       wr_err = 1'b0;
   logic       rd_en = 1'b0;
   logic       clr_overrun = 1'b0;
   logic [7:0] rd_data;
   logic       rd_err;
   logic       rd_valid;
   logic       empty;
   logic       full;
   logic [4:0] count;
   logic       overrun;

   int n_cmp = 0;
   int n_bad = 0;

   logic [8:0] sb [$];
   int         m_count = 0;
   logic       m_overrun = 1'b0;
   logic       m_rv = 1'b0;
   logic [8:0] m_exp = 9'h0;

   always #5 clk = ~clk;

   uart_rx_buffer #(.DATA_BITS(8), .ADDR_WIDTH(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_valid    (wr_valid),
      .wr_data     (wr_data),
      .wr_err      (wr_err),
      .rd_en       (rd_en),
      .rd_data     (rd_data),
      .rd_err      (rd_err),
      .rd_valid    (rd_valid),
      .empty       (empty),
      .full        (full),
      .count       (count),
      .overrun     (overrun),
      .clr_overrun (clr_overrun)
   );

   // One clock of stimulus; the reference model predicts the outcome
   task automatic drive(input logic wv, input logic [7:0] wd, input logic we,
                        input logic re, input logic clr);
      logic wacc;
      wr_valid    = wv;
      wr_data     = wd;
      wr_err      = we;
      rd_en       = re;
      clr_overrun = clr;
      m_rv = re && (m_count != 0);
      wacc = wv && ((m_count != 16) || re);
      if (m_rv) m_exp = sb.pop_front();
      if (wacc) sb.push_back({we, wd});
      if (wacc && !m_rv) m_count++;
      if (m_rv && !wacc) m_count--;
      if (wv && !wacc) m_overrun = 1'b1;
      else if (clr) m_overrun = 1'b0;
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
      rd_en = 1'b0;
      clr_overrun = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(posedge clk);
      #2;
      rst = 1'b0;
      sb.delete();
      m_count = 0;
      m_overrun = 1'b0;
      @(posedge clk);
      #1;
      n_cmp++;
      if ({count, empty, full, overrun, rd_valid, rd_err, rd_data} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
         n_bad++;
         $display("FAIL reset_state: got cnt=%0d e=%b f=%b ov=%b rv=%b data=%h expected cnt=0 e=1 f=0 ov=0 rv=0 data=00",
                  count, empty, full, overrun, rd_valid, rd_data);
      end
   endtask

   task automatic test_single();
      drive(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (count !== 5'd1 || empty !== 1'b0) begin
         n_bad++;
         $display("FAIL single_write: got cnt=%0d e=%b expected cnt=1 e=0", count, empty);
      end
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (rd_valid !== 1'b1 || {rd_err, rd_data} !== m_exp || empty !== 1'b1) begin
         n_bad++;
         $display("FAIL single_read: got rv=%b ent=%h e=%b expected rv=1 ent=%h e=1", rd_valid, {rd_err, rd_data}, empty, m_exp);
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (rd_valid !== 1'b0 || rd_data !== 8'hA5) begin
         n_bad++;
         $display("FAIL single_pulse: got rv=%b data=%h expected rv=0 data=a5", rd_valid, rd_data);
      end
   endtask

   task automatic fill16();
      for (int i = 0; i < 16; i++) drive(1'b1, 8'(i), 1'(i % 3 == 0), 1'b0, 1'b0);
   endtask

   task automatic drain(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
         n_cmp++;
         if (rd_valid !== m_rv || (m_rv && {rd_err, rd_data} !== m_exp) || count !== 5'(m_count)) begin
            n_bad++;
            $display("FAIL %s_read%0d: got rv=%b ent=%h cnt=%0d expected rv=%b ent=%h cnt=%0d",
                     tag, i, rd_valid, {rd_err, rd_data}, count, m_rv, m_exp, m_count);
         end
      end
      n_cmp++;
      if (empty !== 1'b1 || full !== 1'b0 || count !== 5'd0) begin
         n_bad++;
         $display("FAIL %s_empty: got e=%b f=%b cnt=%0d expected e=1 f=0 cnt=0", tag, empty, full, count);
      end
   endtask

   task automatic test_fill_drain();
      fill16();
      n_cmp++;
      if (full !== 1'b1 || count !== 5'd16 || empty !== 1'b0) begin
         n_bad++;
         $display("FAIL fill_full: got f=%b cnt=%0d e=%b expected f=1 cnt=16 e=0", full, count, empty);
      end
      drain(16, "fill");
      n_cmp++;
      if (rd_data !== 8'h0F) begin
         n_bad++;
         $display("FAIL fill_last: got %h expected 0f", rd_data);
      end
   endtask

   task automatic test_overrun();
      fill16();
      drive(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
      n_cmp++;
      if (overrun !== 1'b1 || count !== 5'd16 || full !== 1'b1) begin
         n_bad++;
         $display("FAIL overrun_set: got ov=%b cnt=%0d f=%b expected ov=1 cnt=16 f=1", overrun, count, full);
      end
      drain(16, "ovr");
      n_cmp++;
      if (overrun !== 1'b1) begin
         n_bad++;
         $display("FAIL overrun_sticky: got %b expected 1", overrun);
      end
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
      n_cmp++;
      if (overrun !== m_overrun || m_overrun !== 1'b0) begin
         n_bad++;
         $display("FAIL overrun_clear: got %b expected 0", overrun);
      end
   endtask

   task automatic test_full_rw();
      fill16();
      drive(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (rd_valid !== 1'b1 || {rd_err, rd_data} !== m_exp || count !== 5'd16 || overrun !== 1'b0 || full !== 1'b1) begin
         n_bad++;
         $display("FAIL full_rw: got rv=%b ent=%h cnt=%0d ov=%b f=%b expected rv=1 ent=%h cnt=16 ov=0 f=1",
                  rd_valid, {rd_err, rd_data}, count, overrun, full, m_exp);
      end
      drain(16, "fullrw");
      n_cmp++;
      if ({rd_err, rd_data} !== 9'h077) begin
         n_bad++;
         $display("FAIL fullrw_last: got %h expected 077", {rd_err, rd_data});
      end
   endtask

   task automatic test_empty_rw();
      drive(1'b1, 8'h3C, 1'b1, 1'b1, 1'b0);
      n_cmp++;
      if (rd_valid !== 1'b0 || count !== 5'd1 || empty !== 1'b0) begin
         n_bad++;
         $display("FAIL empty_rw: got rv=%b cnt=%0d e=%b expected rv=0 cnt=1 e=0", rd_valid, count, empty);
      end
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (rd_valid !== 1'b1 || rd_data !== 8'h3C || rd_err !== 1'b1 || {rd_err, rd_data} !== m_exp) begin
         n_bad++;
         $display("FAIL empty_rw_read: got rv=%b err=%b data=%h expected rv=1 err=1 data=3c", rd_valid, rd_err, rd_data);
      end
   endtask

   task automatic test_reset_mid();
      drive(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (rd_valid !== 1'b1 || rd_data !== 8'h11 || count !== 5'd2) begin
         n_bad++;
         $display("FAIL premid_read: got rv=%b data=%h cnt=%0d expected rv=1 data=11 cnt=2", rd_valid, rd_data, count);
      end
      rd_en = 1'b1;
      rst = 1'b1;
      #1;
      n_cmp++;
      if (count !== 5'd0 || empty !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 8'h00 || rd_err !== 1'b0) begin
         n_bad++;
         $display("FAIL mid_reset: got cnt=%0d e=%b rv=%b data=%h expected cnt=0 e=1 rv=0 data=00",
                  count, empty, rd_valid, rd_data);
      end
      @(posedge clk);
      #2;
      rst = 1'b0;
      rd_en = 1'b0;
      sb.delete();
      m_count = 0;
      m_overrun = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
         n_cmp++;
         if (rd_valid !== 1'b0 || count !== 5'd0 || empty !== 1'b1) begin
            n_bad++;
            $display("FAIL postreset_read%0d: got rv=%b cnt=%0d e=%b expected rv=0 cnt=0 e=1", i, rd_valid, count, empty);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill_drain();
      test_overrun();
      test_full_rw();
      test_empty_rw();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_rx_buffer.md
# uart_rx_buffer

Receive-side byte FIFO that sits directly downstream of the UART receiver. It captures each completed byte and its error flag, then holds them until the consumer reads them out, for example the LED/display logic or a command parser. It decouples the bursty serial arrival rate from the consumer. It also reports occupancy and a sticky overrun flag when bytes are lost.

## Interface
Parameters:
- DATA_BITS, 8, width of one received data word
- ADDR_WIDTH, 4, log2 of FIFO depth (depth = 2^ADDR_WIDTH = 16)

Ports:
- clk, input, 1, system clock (50 MHz board clock)
- rst, input, 1, asynchronous, active-high reset
- wr_valid, input, 1, one-cycle pulse from receiver: byte complete
- wr_data, input, DATA_BITS, received byte, qualified by wr_valid
- wr_err, input, 1, parity/framing error of that byte, qualified by wr_valid
- rd_en, input, 1, consumer read request (level; one entry per cycle)
- rd_data, output, DATA_BITS, byte popped by the last accepted read
- rd_err, output, 1, error flag stored with rd_data
- rd_valid, output, 1, one-cycle pulse: rd_data/rd_err updated
- empty, output, 1, count == 0
- full, output, 1, count == 2^ADDR_WIDTH
- count, output, ADDR_WIDTH+1, number of stored entries
- overrun, output, 1, sticky: a write was dropped because FIFO was full
- clr_overrun, input, 1, one-cycle pulse clearing overrun

## Operation
- Each entry stores {wr_err, wr_data} (DATA_BITS+1 bits).
- Write accept: wr_valid && (!full || rd_en). The entry goes to mem[wr_ptr] and wr_ptr increments.
- Read accept: rd_en && !empty. The entry mem[rd_ptr] is registered to rd_data/rd_err, rd_valid pulses high, and rd_ptr increments.
- rd_en while empty is ignored: there is no rd_valid pulse and rd_data holds its value.
- There is no fall-through. A simultaneous write and read on an empty FIFO accepts only the write. Its data becomes readable from the next cycle.
- A simultaneous write and read on a full FIFO accepts both. count stays at 2^ADDR_WIDTH and overrun is not set.
- wr_valid on a full FIFO without rd_en drops the byte and sets overrun. Pointers and count are unchanged.
- count: +1 on write only, -1 on read only, unchanged on both or neither. It saturates logically at 0..2^ADDR_WIDTH by the accept rules above.
- Pointers are ADDR_WIDTH bits wide and wrap modulo 2^ADDR_WIDTH. empty and full derive from count, not from pointer compare.
- overrun: set on a dropped write and cleared by clr_overrun. Set wins when both occur in the same cycle.
- Reset, asynchronous and taking effect immediately:
  - wr_ptr = rd_ptr = 0 and count = 0
  - empty = 1, full = 0, overrun = 0
  - rd_data = 0, rd_err = 0, rd_valid = 0
- Memory contents are not reset.
- Reset mid-operation discards all stored entries. No rd_valid is issued for the in-flight read.

## Timing
- Write-to-readable latency: an entry written at edge N sets empty = 0 after edge N. rd_en asserted in cycle N+1 gives rd_valid and rd_data after edge N+2.
- Read latency: 1 cycle from an accepted rd_en to rd_valid/rd_data.
- Continuous rd_en drains one entry per cycle, with back-to-back rd_valid.
- count, empty, full and overrun are registered and update on the edge that performs the operation.
- All outputs are registered. There is no combinational path from any input to any output.

## Structure
- Shared package uart_pkg:
  - DATA_BITS default
  - parity-type encoding constants: 0 none, 1 odd, 2 even
  - entry width constant (DATA_BITS+1)
- Sub-module uart_fifo_ram holds the storage: a simple dual-port array with 1 write port and 1 registered read port, parameterised by width and ADDR_WIDTH.
- uart_rx_buffer keeps the pointers, count, flags and accept logic.

## Test plan
- Reset, then write 0xA5 (err = 0) -> count = 1 and empty = 0. rd_en then gives rd_data = 0xA5, rd_err = 0 and one rd_valid pulse, followed by empty = 1.
- Write 16 bytes 0x00..0x0F -> full = 1 and count = 16. Read 16 -> same order, with 0x0F last, then empty = 1. This pass covers pointer wrap.
- Full FIFO plus write 0x55 with no read -> byte dropped, overrun = 1, count = 16. The next 16 reads return 0x00..0x0F. clr_overrun -> overrun = 0.
- Full FIFO with simultaneous wr_valid (0x77) and rd_en -> rd_data = oldest entry, count stays 16, overrun = 0. The 16th subsequent read returns 0x77.
- Empty FIFO with simultaneous wr_valid (0x3C, err = 1) and rd_en -> no rd_valid that cycle and count = 1. The next read gives 0x3C with rd_err = 1.
- Three entries stored, then rst pulsed mid-read -> count = 0, empty = 1, rd_valid = 0, rd_data = 0 immediately. rd_en afterwards produces no rd_valid.
